seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised iterative shift-add multiplier with valid/ready handshakes on both sides, producing a 2·WIDTH-bit product. It is the sequential successor to the combinational 8×8 multiplier used by the ALU: one adder instead of a full reduction tree, trading latency for area. It sits behind the ALU as a multi-cycle functional unit that the processor stalls on.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; not overridden).
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- A  in  WIDTH  multiplicand; sampled on accept.
- B  in  WIDTH  multiplier; sampled on accept.
- SIGN_MODE  in  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- IN_VALID  in  1  operand request.
- IN_READY  out  1  unit can accept operands.
- Y  out  2·WIDTH  product.
- OUT_VALID  out  1  Y is valid.
- OUT_READY  in  1  consumer takes Y.
- BUSY  out  1  a multiply is in progress (state BUSY).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - IN_READY=1. On IN_VALID: latch the operands, clear the accumulator, set counter=0, go to BUSY.
  - Signed mode: latch |A| and |B| as WIDTH-bit unsigned values (|−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned). Latch result sign = A[msb]^B[msb].
- BUSY, one step per cycle:
  - If multiplier LSB=1, add the multiplicand to the upper half of the {acc, mult} register. The (WIDTH+1)-bit sum keeps the carry.
  - Shift the whole register right 1.
  - Increment the counter. When counter reaches WIDTH−1, go to DONE.
- DONE:
  - Y = product, two's-complement negated if the result sign is 1 (signed mode only). OUT_VALID=1.
  - On OUT_READY, go to IDLE.
  - Y and OUT_VALID are held stable until OUT_READY is seen.
- IN_READY=0 in BUSY and DONE. IN_VALID is ignored there, and operands are not queued.
- Y holds its last value in IDLE. It is cleared only by reset.
- Arithmetic is exact, with no overflow: the full 2·WIDTH product is always returned.

## Timing
- Accept edge = edge 0. BUSY occupies edges 1..WIDTH. OUT_VALID rises after edge WIDTH: latency WIDTH cycles, accept to OUT_VALID.
- Handshake completes on the edge where OUT_VALID & OUT_READY. IN_READY rises in the following cycle. Throughput is one result per WIDTH+2 cycles with OUT_READY tied high.
- OUT_READY asserted before OUT_VALID has no effect.
- Reset values: state IDLE, IN_READY=1, OUT_VALID=0, BUSY=0, Y=0, internal registers 0.
- RESET asserted mid-operation aborts immediately, with no partial result. The first accept is possible in the cycle after RESET deasserts.
- All outputs are registered except IN_READY, which is decoded from state.

## Configuration
- SEQ_MULTIPLIER_SIGNED_EN defined: SIGN_MODE is honoured, and the magnitude/negation logic is present.
- Not defined: the SIGN_MODE port remains but is ignored. All operations are unsigned, and the abs/negate logic is removed.

## Structure
- Shared package mul_pkg holds:
  - the state enum type (IDLE, BUSY, DONE);
  - the default WIDTH constant;
  - a function computing the counter width.
- One sub-module, mul_step: a combinational single iteration (conditional add + shift right) over the {acc, mult} register, instantiated once.

## Test plan
- Unsigned, WIDTH=8: A=5, B=6, OUT_READY=1 → OUT_VALID after 8 cycles, Y=30.
- Unsigned max: A=255, B=255 → Y=65025 (0xFE01); zero operand: A=0, B=200 → Y=0.
- Signed (macro on): A=−128, B=−128 → Y=0x4000. A=−3, B=5 → Y=0xFFF1. Same operands with SIGN_MODE=0 → A=253, B=5 → Y=1265.
- Back-pressure: hold OUT_READY=0 for 5 cycles in DONE, pulsing IN_VALID with new operands → Y stable, OUT_VALID high, IN_READY=0, new operands not accepted.
- Reset mid-op: RESET at cycle 3 of BUSY → all outputs at reset values. The next accept A=7, B=9 → Y=63 after 8 cycles.
- WIDTH=16: A=1000, B=1000 → Y=1000000 after 16 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration over the {acc, mult} register pair.
module mul_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mult_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mult_o
);

  logic [WIDTH:0] sum;

  // The sum is one bit wider so the carry lands in acc's MSB after the shift.
  assign sum    = {1'b0, acc_i} + {1'b0, (mult_i[0] ? mcand_i : '0)};
  assign acc_o  = sum[WIDTH:1];
  assign mult_o = {sum[0], mult_i[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH cycles per product, valid/ready on both sides.
// Define SEQ_MULTIPLIER_SIGNED_EN to honour SIGN_MODE (two's-complement operands).
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               SIGN_MODE,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [2*WIDTH-1:0] Y,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               BUSY
);

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mult_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] y_q;
  logic               ovld_q;
  logic               busy_q;

  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   mult_d;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [2*WIDTH-1:0] prod_d;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mult_i  (mult_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_d),
    .mult_o  (mult_d)
  );

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic neg_q;
  logic neg_in;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is correct when read unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return v[WIDTH-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic neg);
    return neg ? -p : p;
  endfunction

  assign a_in   = SIGN_MODE ? magnitude(A) : A;
  assign b_in   = SIGN_MODE ? magnitude(B) : B;
  assign neg_in = SIGN_MODE & (A[WIDTH-1] ^ B[WIDTH-1]);
  assign prod_d = apply_sign({acc_d, mult_d}, neg_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      neg_q <= 1'b0;
    end else if (state_q == ST_IDLE && IN_VALID) begin
      neg_q <= neg_in;
    end
  end
`else
  logic unused_sign_mode;

  assign unused_sign_mode = SIGN_MODE;
  assign a_in             = A;
  assign b_in             = B;
  assign prod_d           = {acc_d, mult_d};
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mult_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      ovld_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IN_VALID) begin
            mcand_q <= a_in;
            mult_q  <= b_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_q  <= acc_d;
          mult_q <= mult_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          // Last step: register the finished product straight from the step output.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            y_q     <= prod_d;
            ovld_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            ovld_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign Y         = y_q;
  assign OUT_VALID = ovld_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=8 and WIDTH=16 instances).
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        sm8 = 1'b0, iv8 = 1'b0, or8 = 1'b1;
  logic        ir8, ov8, busy8;
  logic [15:0] y8;

  logic [15:0] a16 = '0, b16 = '0;
  logic        sm16 = 1'b0, iv16 = 1'b0, or16 = 1'b1;
  logic        ir16, ov16, busy16;
  logic [31:0] y16;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET(rst), .A(a8), .B(b8), .SIGN_MODE(sm8),
    .IN_VALID(iv8), .IN_READY(ir8), .Y(y8), .OUT_VALID(ov8),
    .OUT_READY(or8), .BUSY(busy8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .CLK(clk), .RESET(rst), .A(a16), .B(b16), .SIGN_MODE(sm16),
    .IN_VALID(iv16), .IN_READY(ir16), .Y(y16), .OUT_VALID(ov16),
    .OUT_READY(or16), .BUSY(busy16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sm, input logic [15:0] exp_y);
    int cyc;
    check_eq({tag, "_rdy"}, 64'(ir8), 64'd1);
    a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    check_eq({tag, "_busy"}, 64'(busy8), 64'd1);
    cyc = 0;
    while (!ov8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_lat"}, 64'(cyc), 64'd8);
    check_eq({tag, "_y"}, 64'(y8), 64'(exp_y));
    if (or8) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] exp_neg;
    int cyc;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(ir8), 64'd1);
    check_eq("rst_out_valid", 64'(ov8), 64'd0);
    check_eq("rst_busy", 64'(busy8), 64'd0);
    check_eq("rst_y", 64'(y8), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    mul8("u5x6", 8'd5, 8'd6, 1'b0, 16'd30);
    check_eq("u5x6_ready_after", 64'(ir8), 64'd1);
    mul8("umax", 8'd255, 8'd255, 1'b0, 16'hFE01);
    mul8("uzero", 8'd0, 8'd200, 1'b0, 16'd0);
    mul8("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    exp_neg = 16'hFFF1;
`else
    exp_neg = 16'd1265;
`endif
    mul8("s_m3x5", 8'hFD, 8'd5, 1'b1, exp_neg);
    mul8("u253x5", 8'hFD, 8'd5, 1'b0, 16'd1265);

    // Back-pressure: result must hold while new requests are ignored.
    or8 = 1'b0;
    mul8("bp", 8'd12, 8'd11, 1'b0, 16'd132);
    for (int i = 0; i < 5; i++) begin
      a8 = 8'd3; b8 = 8'd3; iv8 = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_y_hold", 64'(y8), 64'd132);
      check_eq("bp_ovld_hold", 64'(ov8), 64'd1);
      check_eq("bp_in_ready", 64'(ir8), 64'd0);
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_ovld", 64'(ov8), 64'd0);
    check_eq("bp_release_rdy", 64'(ir8), 64'd1);
    check_eq("bp_y_idle_hold", 64'(y8), 64'd132);
    check_eq("bp_no_accept", 64'(busy8), 64'd0);

    // Abort mid-operation.
    a8 = 8'd100; b8 = 8'd100; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_in_ready", 64'(ir8), 64'd1);
    check_eq("abort_out_valid", 64'(ov8), 64'd0);
    check_eq("abort_busy", 64'(busy8), 64'd0);
    check_eq("abort_y", 64'(y8), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mul8("post_rst_7x9", 8'd7, 8'd9, 1'b0, 16'd63);

    // Wide instance.
    a16 = 16'd1000; b16 = 16'd1000; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    cyc = 0;
    while (!ov16 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("w16_lat", 64'(cyc), 64'd16);
    check_eq("w16_y", 64'(y16), 64'd1000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
